// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide unit with HI/LO registers.
// Runs MULT/MULTU (radix-2 shift-add) and DIV/DIVU (restoring division).
// Every op takes 33 edges from the start edge to the HI/LO update.
// MTHI/MTLO writes are accepted only while idle.
// Ports:
//   clock, reset           clock; asynchronous active-high reset
//   start, op[1:0]         launch op (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   srcA, srcB             operands, captured on the accepting edge
//   writeHi/writeLo/Data   MTHI / MTLO
//   hiQ, loQ               HI / LO result registers
//   busy, done, divByZero  status (done/divByZero are one-cycle pulses)
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             writeHi,
  input  logic             writeLo,
  input  logic [WIDTH-1:0] writeData,
  output logic [WIDTH-1:0] hiQ,
  output logic [WIDTH-1:0] loQ,
  output logic             busy,
  output logic             done,
  output logic             divByZero
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic               is_div, sign_a, sign_b;
  logic [WIDTH-1:0]   opa, opb, raw_a;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;  // product, or {remainder, quotient}

  // Operand sign handling at the accepting edge (op[0]=0 means signed)
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign a_neg = ~op[0] & srcA[WIDTH-1];
  assign b_neg = ~op[0] & srcB[WIDTH-1];
  assign mag_a = a_neg ? -srcA : srcA;
  assign mag_b = b_neg ? -srcB : srcB;

  // Multiply step: add multiplicand into the upper half, shift right.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (opb[0] ? {1'b0, opa} : '0);

  // Divide step: shift next dividend bit into the 33-bit partial remainder
  // and try subtracting the divisor; the extra top bit is the borrow.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_ok;
  assign div_shift = {acc[2*WIDTH-1:WIDTH], opa[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b0, opb};
  assign div_ok    = ~div_diff[WIDTH+1];

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               dbz;
  assign prod_fix = (sign_a ^ sign_b) ? -acc : acc;
  assign quo_fix  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  // opb is only shifted for multiplies, so it still holds the divisor here
  assign dbz      = is_div & (opb == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      is_div    <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      raw_a     <= '0;
      cnt       <= '0;
      acc       <= '0;
      hiQ       <= '0;
      loQ       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      divByZero <= 1'b0;
    end else begin
      done      <= 1'b0;
      divByZero <= 1'b0;
      case (state)
        IDLE: begin
          if (writeHi) hiQ <= writeData;
          if (writeLo) loQ <= writeData;
          if (start) begin
            state  <= CALC;
            busy   <= 1'b1;
            is_div <= op[1];
            sign_a <= a_neg;
            sign_b <= b_neg;
            opa    <= mag_a;
            opb    <= mag_b;
            raw_a  <= srcA;
            cnt    <= '0;
            acc    <= '0;
          end
        end
        CALC: begin
          if (is_div) begin
            acc[2*WIDTH-1:WIDTH] <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            acc[WIDTH-1:0]       <= {acc[WIDTH-2:0], div_ok};
            opa                  <= {opa[WIDTH-2:0], 1'b0};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
            opb <= opb >> 1;
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b1;
          divByZero <= dbz;
          if (dbz) begin
            hiQ <= raw_a;
            loQ <= '1;
          end else if (is_div) begin
            hiQ <= rem_fix;
            loQ <= quo_fix;
          end else begin
            hiQ <= prod_fix[2*WIDTH-1:WIDTH];
            loQ <= prod_fix[WIDTH-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit. Expected HI/LO are
// produced by a behavioural model when an op is launched and compared when
// done pulses.
module tb_mult_div_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] srcA = '0, srcB = '0;
  logic        writeHi = 1'b0, writeLo = 1'b0;
  logic [31:0] writeData = '0;
  logic [31:0] hiQ, loQ;
  logic        busy, done, divByZero;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .srcA(srcA), .srcB(srcB), .writeHi(writeHi), .writeLo(writeLo),
    .writeData(writeData), .hiQ(hiQ), .loQ(loQ), .busy(busy),
    .done(done), .divByZero(divByZero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sbv;
    e.dbz = 1'b0;
    e.hi  = '0;
    e.lo  = '0;
    sa    = longint'($signed(a));
    sbv   = longint'($signed(b));
    case (o)
      2'b00: begin p = 64'(sa * sbv); e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (b == 0) begin
          e.hi = a; e.lo = 32'hFFFFFFFF; e.dbz = 1'b1;
        end else if (o == 2'b10) begin
          e.lo = 32'(sa / sbv); e.hi = 32'(sa % sbv);
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  // Scoreboard check on every done pulse
  always @(negedge clock) begin
    if (done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi", hiQ, e.hi);
        chk("lo", loQ, e.lo);
        chk("dbz", divByZero, e.dbz);
        chk("busy_at_done", busy, 0);
      end
    end
  end

  // Count edges until done; expected count given by caller.
  task automatic wait_done(input string tag, input int exp_n);
    int n;
    n = 0;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clock); #1;
      if (done) begin n = i; break; end
    end
    chk(tag, n, exp_n);
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    start = 1'b1; op = o; srcA = a; srcB = b;
    sb.push_back(model(o, a, b));
    @(posedge clock); #1;
    start = 1'b0;
    chk("busy_e0", busy, 1);
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    launch(o, a, b);
    wait_done("latency", 33);
    @(posedge clock); #1;
    chk("done_clear", done, 0);
    chk("dbz_clear", divByZero, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_hi", hiQ, 0);
    chk("rst_lo", loQ, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", divByZero, 0);
    @(negedge clock); reset = 1'b0;

    // Directed arithmetic cases
    do_op(2'b00, 32'd7, 32'hFFFFFFFD);
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op(2'b10, 32'hFFFFFFF9, 32'd2);
    do_op(2'b11, 32'd100, 32'd0);
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
    do_op(2'b10, 32'hFFFFFF9C, 32'd0);   // signed div by zero keeps raw srcA
    do_op(2'b10, 32'd17, 32'hFFFFFFFB);

    // Start and MTHI while busy are ignored
    launch(2'b01, 32'd3, 32'd5);
    repeat (9) @(posedge clock);
    @(negedge clock);
    start = 1'b1; srcA = 32'd9; srcB = 32'd9;
    writeHi = 1'b1; writeData = 32'hDEADBEEF;
    @(posedge clock); #1;
    start = 1'b0; writeHi = 1'b0;
    wait_done("busy_ign_latency", 23);
    @(negedge clock);
    writeLo = 1'b1; writeData = 32'h12345678;
    @(posedge clock); #1;
    writeLo = 1'b0;
    chk("mtlo_lo", loQ, 32'h12345678);
    chk("mtlo_hi", hiQ, 0);
    @(negedge clock);
    writeHi = 1'b1; writeLo = 1'b1; writeData = 32'hA5A55A5A;
    @(posedge clock); #1;
    writeHi = 1'b0; writeLo = 1'b0;
    chk("both_hi", hiQ, 32'hA5A55A5A);
    chk("both_lo", loQ, 32'hA5A55A5A);
    repeat (3) @(posedge clock); #1;
    chk("hold_hi", hiQ, 32'hA5A55A5A);

    // Asynchronous reset mid-operation
    launch(2'b11, 32'd1000, 32'd7);
    repeat (19) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_hi", hiQ, 0);
    chk("arst_lo", loQ, 0);
    sb.delete();
    @(negedge clock); reset = 1'b0;
    do_op(2'b11, 32'd1000, 32'd7);

    // Back-to-back with start held high
    @(negedge clock);
    start = 1'b1; op = 2'b01; srcA = 32'd2; srcB = 32'd3;
    sb.push_back(model(2'b01, 32'd2, 32'd3));
    sb.push_back(model(2'b01, 32'd4, 32'd5));
    @(posedge clock); #1;
    srcA = 32'd4; srcB = 32'd5;
    wait_done("b2b_first", 33);
    @(posedge clock); #1;
    chk("b2b_accept", busy, 1);
    start = 1'b0;
    wait_done("b2b_second", 33);

    // Randomised ops
    for (int k = 0; k < 8; k++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom();
      rb = (k == 3) ? 32'd0 : ((k % 2) ? $urandom() : 32'($urandom_range(1, 300)));
      if (k == 5) ra = 32'h80000000;
      do_op(ro, ra, rb);
    end

    repeat (2) @(posedge clock);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
